dmem_arbiter: RTL and testbench

- Arbitrates the single-port data SRAM between the core load/store path (port C, priority) and the debug/loader port (port D, word-only).
- Sequences sub-word stores (SB/SH) as a read-modify-write, so the SRAM needs no byte enables.
- Sits between the execute/memory stage and the data memory. Port C returns the raw aligned word; byte/half extraction stays in the execute unit.

---
 rtl/dmem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data SRAM arbiter with sub-word read-modify-write
module dmem_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  c_req,
   input  logic                  c_we,
   input  logic [1:0]            c_size,
   input  logic [ADDR_WIDTH-1:0] c_addr,
   input  logic [DATA_WIDTH-1:0] c_wdata,
   output logic                  c_gnt,
   output logic                  c_err,
   output logic                  c_rvalid,
   output logic [DATA_WIDTH-1:0] c_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  m_en,
   output logic                  m_we,
   output logic [ADDR_WIDTH-3:0] m_addr,
   output logic [DATA_WIDTH-1:0] m_wdata,
   input  logic [DATA_WIDTH-1:0] m_rdata
);
   localparam int WAW = ADDR_WIDTH - 2;

   typedef enum logic [1:0] {IDLE, RD_WAIT, RMW} state_t;

   state_t                r_state, w_next;
   logic [3:0]            r_starve;
   logic                  r_port_d;
   logic [WAW-1:0]        r_waddr;
   logic                  r_half;
   logic [1:0]            r_off;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_c_rdata, r_d_rdata;

   logic                  w_can_gnt, w_starved, w_gnt_c, w_gnt_d;
   logic                  w_c_byte, w_c_half, w_c_word, w_c_mis;
   logic [1:0]            w_c_off;
   logic [DATA_WIDTH-1:0] w_merged;
   logic                  w_unused;

   // Port D is word-only, so its byte offset bits carry no information.
   assign w_unused  = ^d_addr[1:0];

   assign w_can_gnt = (r_state == IDLE) && enable && !rst;
   assign w_starved = (r_starve == 4'(STARVE_LIMIT));
   assign w_gnt_c   = w_can_gnt && c_req && !(d_req && w_starved);
   assign w_gnt_d   = w_can_gnt && d_req && !w_gnt_c;

   assign w_c_byte  = (c_size == 2'b00);
   assign w_c_half  = (c_size == 2'b01);
   assign w_c_word  = c_size[1];
   assign w_c_mis   = (w_c_half && c_addr[0]) || (w_c_word && (c_addr[1:0] != 2'b00));
   assign w_c_off   = w_c_byte ? c_addr[1:0] : (w_c_half ? {c_addr[1], 1'b0} : 2'b00);

   assign c_gnt     = w_gnt_c;
   assign d_gnt     = w_gnt_d;
   assign c_err     = w_gnt_c && w_c_mis;

   always_comb begin
      w_merged = m_rdata;
      if (r_half)
         w_merged[{r_off[1], 4'b0000} +: 16] = r_wdata[15:0];
      else
         w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
   end

   always_comb begin
      w_next   = r_state;
      m_en     = 1'b0;
      m_we     = 1'b0;
      m_addr   = '0;
      m_wdata  = '0;
      c_rvalid = 1'b0;
      d_rvalid = 1'b0;
      c_rdata  = r_c_rdata;
      d_rdata  = r_d_rdata;
      if (!rst) begin
         case (r_state)
            IDLE: begin
               if (w_gnt_c) begin
                  m_en   = 1'b1;
                  m_addr = c_addr[ADDR_WIDTH-1:2];
                  // Sub-word stores start with a read; the write happens in RMW.
                  m_we   = c_we && w_c_word;
                  if (m_we) m_wdata = c_wdata;
                  if (!c_we)          w_next = RD_WAIT;
                  else if (!w_c_word) w_next = RMW;
               end else if (w_gnt_d) begin
                  m_en   = 1'b1;
                  m_addr = d_addr[ADDR_WIDTH-1:2];
                  m_we   = d_we;
                  if (d_we) m_wdata = d_wdata;
                  else      w_next  = RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (r_port_d) begin
                  d_rvalid = 1'b1;
                  d_rdata  = m_rdata;
               end else begin
                  c_rvalid = 1'b1;
                  c_rdata  = m_rdata;
               end
               w_next = IDLE;
            end
            RMW: begin
               m_en    = 1'b1;
               m_we    = 1'b1;
               m_addr  = r_waddr;
               m_wdata = w_merged;
               w_next  = IDLE;
            end
            default: w_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_starve  <= 4'd0;
         r_c_rdata <= '0;
         r_d_rdata <= '0;
         r_port_d  <= 1'b0;
         r_waddr   <= '0;
         r_half    <= 1'b0;
         r_off     <= 2'b00;
         r_wdata   <= '0;
      end else begin
         r_state <= w_next;
         if (c_rvalid) r_c_rdata <= m_rdata;
         if (d_rvalid) r_d_rdata <= m_rdata;

         if (!d_req || w_gnt_d)
            r_starve <= 4'd0;
         else if (w_gnt_c && !w_starved)
            r_starve <= r_starve + 4'd1;

         if (w_gnt_c) begin
            r_port_d <= 1'b0;
            r_waddr  <= c_addr[ADDR_WIDTH-1:2];
            r_half   <= w_c_half;
            r_off    <= w_c_off;
            r_wdata  <= c_wdata;
         end else if (w_gnt_d) begin
            r_port_d <= 1'b1;
            r_waddr  <= d_addr[ADDR_WIDTH-1:2];
         end
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
   logic        clk = 1'b0;
   logic        rst, enable;
   logic        c_req, c_we;
   logic [1:0]  c_size;
   logic [31:0] c_addr, c_wdata;
   logic        c_gnt, c_err, c_rvalid;
   logic [31:0] c_rdata;
   logic        d_req, d_we;
   logic [31:0] d_addr, d_wdata;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic        m_en, m_we;
   logic [29:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;

   logic [31:0] mem [0:255];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_err(c_err), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
   );

   // Behavioural SRAM with one-cycle read latency.
   always @(posedge clk) begin
      if (m_en && m_we)  mem[m_addr[7:0]] <= m_wdata;
      if (m_en && !m_we) m_rdata <= mem[m_addr[7:0]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic c_set(input logic req, input logic we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
      c_req = req; c_we = we; c_size = sz; c_addr = a; c_wdata = wd;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      m_rdata = 32'h0;
      rst = 1'b1; enable = 1'b1;
      c_set(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
      nxt(); nxt();
      c_req = 1'b1; d_req = 1'b1;
      #1;
      chk("rst_c_gnt", {31'b0, c_gnt}, 32'h0);
      chk("rst_d_gnt", {31'b0, d_gnt}, 32'h0);
      chk("rst_m_en", {31'b0, m_en}, 32'h0);
      chk("rst_c_rdata", c_rdata, 32'h0);
      c_req = 1'b0; d_req = 1'b0;

      // word store then load
      nxt(); rst = 1'b0;
      c_set(1'b1, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF); #1;
      chk("ws_gnt", {31'b0, c_gnt}, 32'h1);
      chk("ws_m_we", {30'b0, m_en, m_we}, 32'h3);
      chk("ws_m_addr", {2'b0, m_addr}, 32'h4);
      chk("ws_m_wdata", m_wdata, 32'hDEADBEEF);
      nxt(); c_set(1'b1, 1'b0, 2'b10, 32'h10, 32'h0); #1;
      chk("ld_gnt", {31'b0, c_gnt}, 32'h1);
      chk("ld_m_we", {30'b0, m_en, m_we}, 32'h2);
      nxt(); c_req = 1'b0; #1;
      chk("ld_rvalid", {31'b0, c_rvalid}, 32'h1);
      chk("ld_rdata", c_rdata, 32'hDEADBEEF);
      nxt(); #1;
      chk("ld_rvalid_low", {31'b0, c_rvalid}, 32'h0);
      chk("ld_rdata_hold", c_rdata, 32'hDEADBEEF);

      // SB / SH read-modify-write
      nxt(); c_set(1'b1, 1'b1, 2'b10, 32'h20, 32'h11223344); #1;
      chk("rmw_init_gnt", {31'b0, c_gnt}, 32'h1);
      nxt(); c_set(1'b1, 1'b1, 2'b00, 32'h22, 32'h000000AA); #1;
      chk("sb_gnt", {31'b0, c_gnt}, 32'h1);
      chk("sb_rd", {30'b0, m_en, m_we}, 32'h2);
      chk("sb_rd_addr", {2'b0, m_addr}, 32'h8);
      nxt(); #1;
      chk("sb_no_gnt", {31'b0, c_gnt}, 32'h0);
      chk("sb_wr", {30'b0, m_en, m_we}, 32'h3);
      chk("sb_wdata", m_wdata, 32'h11AA3344);
      nxt(); c_set(1'b1, 1'b1, 2'b01, 32'h22, 32'h0000BEEF); #1;
      chk("sh_gnt", {31'b0, c_gnt}, 32'h1);
      nxt(); c_req = 1'b0; #1;
      chk("sh_wdata", m_wdata, 32'hBEEF3344);

      // misaligned half load
      nxt(); c_set(1'b1, 1'b0, 2'b01, 32'h13, 32'h0); #1;
      chk("mis_gnt_err", {30'b0, c_gnt, c_err}, 32'h3);
      chk("mis_m_addr", {2'b0, m_addr}, 32'h4);
      nxt(); c_req = 1'b0; #1;
      chk("mis_rdata", c_rdata, 32'hDEADBEEF);

      // reset in the RMW cycle
      nxt(); c_set(1'b1, 1'b1, 2'b10, 32'h20, 32'h11223344); #1;
      nxt(); c_set(1'b1, 1'b1, 2'b00, 32'h22, 32'h000000AA); #1;
      chk("rrst_sb_gnt", {31'b0, c_gnt}, 32'h1);
      nxt(); c_req = 1'b0; rst = 1'b1; #1;
      chk("rrst_no_write", {30'b0, m_en, m_we}, 32'h0);
      nxt(); rst = 1'b0; c_set(1'b1, 1'b0, 2'b10, 32'h20, 32'h0); #1;
      chk("rrst_idle_gnt", {31'b0, c_gnt}, 32'h1);
      nxt(); c_req = 1'b0; #1;
      chk("rrst_rvalid", {31'b0, c_rvalid}, 32'h1);
      chk("rrst_mem", c_rdata, 32'h11223344);

      // starvation: C,C,C,C,D,C,C,C,C,D with continuous word stores
      d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h0BADF00D;
      for (int i = 0; i < 10; i++) begin
         nxt(); c_set(1'b1, 1'b1, 2'b10, 32'h40, 32'h12345678); d_req = 1'b1; #1;
         chk($sformatf("starve_%0d", i), {30'b0, c_gnt, d_gnt},
             (i == 4 || i == 9) ? 32'h1 : 32'h2);
         if (i == 4) chk("starve_d_addr", {2'b0, m_addr}, 32'h11);
      end

      // enable low during RD_WAIT
      nxt(); c_req = 1'b0; d_we = 1'b0; d_addr = 32'h13; d_req = 1'b1; #1;
      chk("en_d_gnt", {31'b0, d_gnt}, 32'h1);
      chk("en_d_addr", {2'b0, m_addr}, 32'h4);
      nxt(); enable = 1'b0; c_set(1'b1, 1'b0, 2'b10, 32'h10, 32'h0); #1;
      chk("en_d_rvalid", {31'b0, d_rvalid}, 32'h1);
      chk("en_d_rdata", d_rdata, 32'hDEADBEEF);
      chk("en_no_gnt_a", {30'b0, c_gnt, d_gnt}, 32'h0);
      nxt(); #1;
      chk("en_no_gnt_b", {29'b0, c_gnt, d_gnt, m_en}, 32'h0);
      nxt(); enable = 1'b1; #1;
      chk("en_resume", {30'b0, c_gnt, d_gnt}, 32'h2);
      nxt(); c_req = 1'b0; d_req = 1'b0;
      nxt();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
